sig_halt_unit: RTL and testbench
================================

// Module: sig_halt_unit
// PURPOSE
//  Store-bus snooper beside the data memory of the RV32IM 5-stage core (with iterative multiplier).
//  Watches memory-stage stores:
//  - stores to SIG_ADDR: write data is queued in a FIFO and drained over a valid/ready stream
//    (signature dump).
//  - a store to HALT_ADDR, or a cycle watchdog expiry: stops capture, drains the FIFO, then asserts halt.
//  Replaces bench-side address snooping, so compliance runs end cleanly in RTL.
// PARAMETERS
//  SIG_ADDR        32'h0000_0F00  store address whose data is captured
//  HALT_ADDR       32'hCAFE_BEEF  store address that requests halt
//  DEPTH           8              FIFO entries; power of two, >=2
//  TIMEOUT_CYCLES  50000          RUN cycles before forced halt; 0 disables watchdog
// PORTS
//  clk          in   1   core clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  wr           in   1   data-memory write strobe, active-low (0 = store this cycle)
//  ALUResultM   in   32  memory-stage store address
//  data_wr      in   32  memory-stage store data
//  sig_data     out  32  FIFO head word
//  sig_valid    out  1   sig_data valid
//  sig_ready    in   1   consumer accepts the head word when sig_valid & sig_ready
//  sig_count    out  16  total words accepted into the FIFO since reset (saturates at 16'hFFFF)
//  overflow     out  1   sticky: a signature store was dropped because the FIFO was full
//  timeout      out  1   sticky: halt was caused by the watchdog
//  halt         out  1   run finished and FIFO drained; stays 1 until reset
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=RUN, FIFO empty, watchdog=0.
//   All outputs 0: sig_valid, sig_data, sig_count, overflow, timeout, halt.
//  Store qualifier: st = ~wr, sampled on every rising clk edge (one store per cycle max).
//  FSM RUN:
//   - st & ALUResultM==SIG_ADDR  -> push data_wr.
//   - st & ALUResultM==HALT_ADDR -> DRAIN next cycle; data not captured.
//   - watchdog: +1 per RUN cycle. Reaching TIMEOUT_CYCLES-1 (when nonzero) -> DRAIN, timeout<=1.
//     If the halt store lands in that same cycle, timeout stays 0 (store wins).
//  FSM DRAIN:
//   - All stores ignored, including to SIG_ADDR; overflow is not set.
//   - Pops continue. When the FIFO is empty and no pop is in flight -> DONE.
//  FSM DONE: halt=1, sig_valid=0, stores ignored. Only reset leaves DONE.
//  FIFO:
//   - Registered. A push into an empty FIFO gives sig_valid=1 on the next cycle (1-cycle latency).
//   - Pop when sig_valid & sig_ready. Head advances on that edge.
//   - sig_data is held stable while sig_valid & ~sig_ready.
//   - Full with push and no pop: word dropped, overflow<=1, sig_count unchanged.
//   - Full with push and pop in the same cycle: both accepted, occupancy unchanged.
//   - Empty with push and pop in the same cycle: pop is impossible (sig_valid=0), push accepted.
//   - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//     full = MSBs differ and low bits equal; empty = pointers equal.
//  sig_count increments only on an accepted push.
//  Rst asserted mid-drain or mid-run: FIFO contents discarded immediately, all state to reset values.
//  Any X on wr after reset is treated as no store.
// TESTING
//  1 Reset, then stores 0xF00<-0x11111111, 0x22222222, 0x33333333; sig_ready=1
//    -> three beats in order, each 1 cycle after its store; sig_count=3.
//  2 sig_ready=0, 10 stores to 0xF00 (data 1..10)
//    -> words 1..8 held, overflow=1, sig_count=8.
//    Then sig_ready=1 -> 1..8 drained in order.
//  3 FIFO full, sig_ready=1, store 0xF00<-0xAA in the same cycle as a pop
//    -> no overflow; 0xAA appears as the 8th beat after the current head.
//  4 Store 0xF00<-5, 0xF00<-6, store 0xCAFEBEEF, store 0xF00<-7; sig_ready=0 for 5 cycles, then 1
//    -> beats 5, 6 only; halt=1 the cycle after the FIFO empties; timeout=0.
//  5 TIMEOUT_CYCLES=100, no stores -> halt=1 at cycle 101 after reset release; timeout=1.
//  6 Async rst pulse mid-cycle while in DRAIN with 4 words queued
//    -> outputs 0 immediately, without waiting for clk; no stale beat after release.

Source files
------------

// File: rtl/sig_halt_unit.sv
// ---------------------------------------------------------------------------
// sig_halt_unit
//
// Store-bus snooper that sits beside the data memory of the RV32IM core.
// It watches memory-stage stores:
//   - Stores to SIG_ADDR are queued in a small FIFO and streamed out over a
//     valid/ready interface (signature dump).
//   - A store to HALT_ADDR, or expiry of the cycle watchdog, stops capture.
//     The unit then drains the FIFO and asserts halt.
//
// Ports
//   clk         in   1   core clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   wr          in   1   data-memory write strobe, active-low (0 = store)
//   ALUResultM  in   32  memory-stage store address
//   data_wr     in   32  memory-stage store data
//   sig_data    out  32  FIFO head word (0 when not valid)
//   sig_valid   out  1   sig_data valid
//   sig_ready   in   1   consumer takes the head word when valid & ready
//   sig_count   out  16  words accepted into the FIFO since reset (saturating)
//   overflow    out  1   sticky: a signature store was dropped (FIFO full)
//   timeout     out  1   sticky: halt was caused by the watchdog
//   halt        out  1   run finished and FIFO drained; held until reset
// ---------------------------------------------------------------------------
module sig_halt_unit #(
    parameter logic [31:0] SIG_ADDR       = 32'h0000_0F00,
    parameter logic [31:0] HALT_ADDR      = 32'hCAFE_BEEF,
    parameter int          DEPTH          = 8,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] data_wr,
    output logic [31:0] sig_data,
    output logic        sig_valid,
    input  logic        sig_ready,
    output logic [15:0] sig_count,
    output logic        overflow,
    output logic        timeout,
    output logic        halt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] WDOG_LAST = (TIMEOUT_CYCLES > 0) ?
                                        32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [31:0] wdog;

    logic        empty;
    logic        full;
    logic        st;
    logic        sig_hit;
    logic        halt_hit;
    logic        wdog_hit;
    logic        pop;
    logic        accept;
    logic        drop;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign sig_valid = !empty && (state != DONE);
    // Head word is gated so the output reads 0 whenever nothing is queued,
    // including straight after reset when the storage itself is unknown.
    assign sig_data  = sig_valid ? mem[rptr[AW-1:0]] : 32'd0;
    assign halt      = (state == DONE);
    assign pop       = sig_valid && sig_ready;

    // Store decode. Written with an if so that an unknown strobe falls into
    // the default branch and is treated as no store.
    always_comb begin
        st       = 1'b0;
        sig_hit  = 1'b0;
        halt_hit = 1'b0;
        wdog_hit = 1'b0;
        if (wr == 1'b0) begin
            st = 1'b1;
        end
        if (st && (state == RUN)) begin
            sig_hit  = (ALUResultM == SIG_ADDR);
            halt_hit = (ALUResultM == HALT_ADDR);
        end
        if ((TIMEOUT_CYCLES != 0) && (state == RUN) && (wdog == WDOG_LAST)) begin
            wdog_hit = 1'b1;
        end
    end

    // A full FIFO can still take a push when the head leaves on the same edge.
    assign accept = sig_hit && (!full || pop);
    assign drop   = sig_hit && full && !pop;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (halt_hit || wdog_hit) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (empty && !pop) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wptr      <= '0;
            rptr      <= '0;
            wdog      <= 32'd0;
            sig_count <= 16'd0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wptr <= wptr + 1'b1;
                if (sig_count != 16'hFFFF) begin
                    sig_count <= sig_count + 16'd1;
                end
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (state == RUN) begin
                wdog <= wdog + 32'd1;
            end
            // A halt store landing on the expiry cycle takes precedence.
            if (wdog_hit && !halt_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    // Storage is data only; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr[AW-1:0]] <= data_wr;
        end
    end

endmodule

// File: tb/tb_sig_halt_unit.sv
// ---------------------------------------------------------------------------
// tb_sig_halt_unit
//
// Self-checking bench for sig_halt_unit. Words expected on the signature
// stream are queued as stores are driven, and a negedge monitor pops and
// compares each handshaken beat. Runs with a short watchdog (100 cycles).
// ---------------------------------------------------------------------------
module tb_sig_halt_unit;

    localparam logic [31:0] SIG = 32'h0000_0F00;
    localparam logic [31:0] HLT = 32'hCAFE_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b1;
    logic [31:0] ALUResultM = 32'd0;
    logic [31:0] data_wr = 32'd0;
    logic        sig_ready = 1'b0;
    logic [31:0] sig_data;
    logic        sig_valid;
    logic [15:0] sig_count;
    logic        overflow;
    logic        timeout;
    logic        halt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sig_halt_unit #(
        .SIG_ADDR      (SIG),
        .HALT_ADDR     (HLT),
        .DEPTH         (8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .ALUResultM(ALUResultM),
        .data_wr   (data_wr),
        .sig_data  (sig_data),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready),
        .sig_count (sig_count),
        .overflow  (overflow),
        .timeout   (timeout),
        .halt      (halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Stream monitor: beats are taken on the edge following a negedge that
    // sees valid & ready. A stalled head must not change.
    logic        stall_seen = 1'b0;
    logic [31:0] stall_data = 32'd0;

    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && sig_valid) begin
                check("hold", sig_data, stall_data);
            end
            if (sig_valid && sig_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(sig_valid), 32'd0);
                end else begin
                    check("beat", sig_data, exp_q.pop_front());
                end
            end
            stall_seen = sig_valid && !sig_ready;
            stall_data = sig_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(sig_valid), 32'd0);
        check({tag, "_data"}, sig_data, 32'd0);
        check({tag, "_count"}, 32'(sig_count), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_tmo"}, 32'(timeout), 32'd0);
        check({tag, "_halt"}, 32'(halt), 32'd0);
    endtask

    // Leaves reset released just after a rising edge, so the next edge is
    // the first RUN cycle.
    task automatic do_reset;
        rst = 1'b1;
        wr = 1'b1;
        sig_ready = 1'b0;
        ALUResultM = 32'd0;
        data_wr = 32'd0;
        tick();
        tick();
        check("q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check_idle_outputs("rst");
        rst = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b0;
        ALUResultM = a;
        data_wr = d;
        tick();
        wr = 1'b1;
        ALUResultM = 32'd0;
    endtask

    initial begin
        logic [31:0] t1d[3];
        t1d = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

        // 1: three stores streamed out back to back with one-cycle latency
        do_reset();
        sig_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(t1d[i]);
            store(SIG, t1d[i]);
            check("t1_lat_valid", 32'(sig_valid), 32'd1);
            check("t1_lat_data", sig_data, t1d[i]);
        end
        repeat (3) tick();
        check("t1_count", 32'(sig_count), 32'd3);
        check("t1_valid", 32'(sig_valid), 32'd0);
        check("t1_q", 32'(exp_q.size()), 32'd0);

        // 2: overflow with the consumer stalled, then drain
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) exp_q.push_back(32'(i));
            store(SIG, 32'(i));
        end
        tick();
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_count", 32'(sig_count), 32'd8);
        check("t2_head", sig_data, 32'd1);
        sig_ready = 1'b1;
        repeat (10) tick();
        check("t2_q", 32'(exp_q.size()), 32'd0);
        check("t2_valid", 32'(sig_valid), 32'd0);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);
        check("t2_count_end", 32'(sig_count), 32'd8);

        // 3: push into a full FIFO on the same edge as a pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h100 + 32'(i));
            store(SIG, 32'h100 + 32'(i));
        end
        check("t3_head", sig_data, 32'h100);
        sig_ready = 1'b1;
        exp_q.push_back(32'hAA);
        store(SIG, 32'hAA);
        check("t3_ovf", 32'(overflow), 32'd0);
        check("t3_count", 32'(sig_count), 32'd9);
        repeat (10) tick();
        check("t3_q", 32'(exp_q.size()), 32'd0);
        check("t3_valid", 32'(sig_valid), 32'd0);

        // 4: halt store stops capture, FIFO drains, then halt
        do_reset();
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd6);
        store(SIG, 32'd5);
        store(SIG, 32'd6);
        store(HLT, 32'h0);
        store(SIG, 32'd7);
        tick();
        check("t4_halt_wait", 32'(halt), 32'd0);
        check("t4_head", sig_data, 32'd5);
        check("t4_count", 32'(sig_count), 32'd2);
        sig_ready = 1'b1;
        tick();
        check("t4_head2", sig_data, 32'd6);
        check("t4_halt_p1", 32'(halt), 32'd0);
        tick();
        check("t4_empty", 32'(sig_valid), 32'd0);
        check("t4_halt_p2", 32'(halt), 32'd0);
        tick();
        check("t4_halt", 32'(halt), 32'd1);
        check("t4_tmo", 32'(timeout), 32'd0);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_q", 32'(exp_q.size()), 32'd0);

        // 5: watchdog expiry with no stores
        do_reset();
        repeat (99) tick();
        check("t5_tmo_early", 32'(timeout), 32'd0);
        check("t5_halt_early", 32'(halt), 32'd0);
        tick();
        check("t5_tmo", 32'(timeout), 32'd1);
        check("t5_halt_c100", 32'(halt), 32'd0);
        tick();
        check("t5_halt_c101", 32'(halt), 32'd1);
        check("t5_valid", 32'(sig_valid), 32'd0);

        // 7: halt store on the expiry cycle wins over the watchdog
        do_reset();
        repeat (99) tick();
        store(HLT, 32'h0);
        check("t7_tmo", 32'(timeout), 32'd0);
        tick();
        check("t7_halt", 32'(halt), 32'd1);
        check("t7_tmo_end", 32'(timeout), 32'd0);

        // 6: asynchronous reset in DRAIN with four words queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h60 + 32'(i));
            store(SIG, 32'h60 + 32'(i));
        end
        store(HLT, 32'h0);
        tick();
        check("t6_pre_valid", 32'(sig_valid), 32'd1);
        check("t6_pre_count", 32'(sig_count), 32'd4);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_async");
        exp_q.delete();
        tick();
        rst = 1'b0;
        sig_ready = 1'b1;
        repeat (5) tick();
        check("t6_no_stale", 32'(sig_valid), 32'd0);
        check("t6_count", 32'(sig_count), 32'd0);
        check("t6_halt", 32'(halt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
